// File: rtl/adc_event_irq_ctrl.sv
// Interrupt controller for adc_event_ctrl level flags: sticky W1C status, overflow,
// priority id, a single hold-off-spaced interrupt line and a saturating assertion counter.
module adc_event_irq_ctrl #(
  parameter int NUM_EVT   = 10,
  parameter int HOLDOFF_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 adc_wclk,
  input  logic                 adc_wclk_rst,
  input  logic [NUM_EVT-1:0]   data_event_intr,
  input  logic                 irq_en,
  input  logic [NUM_EVT-1:0]   irq_status_clr,
  input  logic [HOLDOFF_W-1:0] irq_holdoff,
  output logic [NUM_EVT-1:0]   irq_status,
  output logic [NUM_EVT-1:0]   irq_ovf,
  output logic [3:0]           irq_id,
  output logic                 irq_out,
  output logic [CNT_W-1:0]     irq_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  irq_state_t             state, state_nxt;
  logic [NUM_EVT-1:0]     evt_d;
  logic [NUM_EVT-1:0]     rise;
  logic [HOLDOFF_W-1:0]   cnt;
  logic                   load_cnt;
  logic                   irq_start;

  // Lowest set index wins; 4'hF means nothing pending.
  function automatic logic [3:0] prio_enc(input logic [NUM_EVT-1:0] s);
    logic [3:0] id;
    id = 4'hF;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (s[i]) id = 4'(i);
    end
    return id;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage p0: edge detect against the previous cycle's levels.
  assign rise = data_event_intr & ~evt_d;

  always_ff @(posedge adc_wclk) begin
    if (adc_wclk_rst) begin
      evt_d      <= '0;
      irq_status <= '0;
      irq_ovf    <= '0;
    end else begin
      evt_d      <= data_event_intr;
      irq_status <= (irq_status & ~irq_status_clr) | rise;
      irq_ovf    <= (irq_ovf & ~irq_status_clr) | (rise & irq_status & ~irq_status_clr);
    end
  end

  // Stage p1: id follows the registered status; FSM decides the line from it.
  assign irq_id = prio_enc(irq_status);

  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    irq_start = 1'b0;
    case (state)
      IDLE: begin
        if (irq_en && (|irq_status)) begin
          state_nxt = ASSERT;
          irq_start = 1'b1;
        end
      end
      ASSERT: begin
        if (!(|irq_status) || !irq_en) begin
          if (irq_holdoff == '0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLDOFF;
            load_cnt  = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (cnt <= HOLDOFF_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge adc_wclk) begin
    if (adc_wclk_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      irq_out   <= 1'b0;
      irq_count <= '0;
    end else begin
      state   <= state_nxt;
      irq_out <= (state_nxt == ASSERT);
      if (load_cnt) begin
        cnt <= irq_holdoff;
      end else if (state == HOLDOFF && cnt != '0) begin
        cnt <= cnt - HOLDOFF_W'(1);
      end
      if (irq_start) irq_count <= sat_inc(irq_count);
    end
  end

endmodule

// File: tb/tb_adc_event_irq_ctrl.sv
// Directed bench for adc_event_irq_ctrl with hand-computed expectations.
module tb_adc_event_irq_ctrl;

  logic        adc_wclk = 1'b0;
  logic        adc_wclk_rst;
  logic [9:0]  data_event_intr;
  logic        irq_en;
  logic [9:0]  irq_status_clr;
  logic [7:0]  irq_holdoff;
  logic [9:0]  irq_status;
  logic [9:0]  irq_ovf;
  logic [3:0]  irq_id;
  logic        irq_out;
  logic [15:0] irq_count;

  int n_cmp = 0;
  int n_bad = 0;

  adc_event_irq_ctrl dut (
    .adc_wclk        (adc_wclk),
    .adc_wclk_rst    (adc_wclk_rst),
    .data_event_intr (data_event_intr),
    .irq_en          (irq_en),
    .irq_status_clr  (irq_status_clr),
    .irq_holdoff     (irq_holdoff),
    .irq_status      (irq_status),
    .irq_ovf         (irq_ovf),
    .irq_id          (irq_id),
    .irq_out         (irq_out),
    .irq_count       (irq_count)
  );

  always #5 adc_wclk = ~adc_wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge adc_wclk);
    #1;
  endtask

  initial begin
    adc_wclk_rst    = 1'b1;
    data_event_intr = '0;
    irq_en          = 1'b1;
    irq_status_clr  = '0;
    irq_holdoff     = 8'd0;
    repeat (3) tick();
    chk("rst_status", 32'(irq_status), 32'h000);
    chk("rst_ovf",    32'(irq_ovf),    32'h000);
    chk("rst_id",     32'(irq_id),     32'hF);
    chk("rst_out",    32'(irq_out),    32'h0);
    chk("rst_count",  32'(irq_count),  32'h0);
    adc_wclk_rst = 1'b0;

    // Quiet inputs after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_out", 32'(irq_out), 32'h0);
      chk("t1_id",  32'(irq_id),  32'hF);
    end
    chk("t1_status", 32'(irq_status), 32'h000);

    // Single event on bit 3
    data_event_intr = 10'h008;
    tick();
    chk("t2_status", 32'(irq_status), 32'h008);
    chk("t2_id",     32'(irq_id),     32'h3);
    chk("t2_out_k",  32'(irq_out),    32'h0);
    tick();
    chk("t2_out_k1", 32'(irq_out),    32'h1);
    chk("t2_count",  32'(irq_count),  32'h1);
    data_event_intr = '0;
    irq_status_clr  = 10'h008;
    tick();
    irq_status_clr  = '0;
    chk("t2_clr_status", 32'(irq_status), 32'h000);
    chk("t2_clr_out_k",  32'(irq_out),    32'h1);
    chk("t2_clr_id",     32'(irq_id),     32'hF);
    tick();
    chk("t2_clr_out_k1", 32'(irq_out),    32'h0);

    // Bits 2 and 5 together: priority and partial clear
    data_event_intr = 10'h024;
    tick();
    chk("t3_status", 32'(irq_status), 32'h024);
    chk("t3_id2",    32'(irq_id),     32'h2);
    tick();
    chk("t3_out",    32'(irq_out),    32'h1);
    data_event_intr = '0;
    irq_status_clr  = 10'h004;
    tick();
    irq_status_clr  = '0;
    chk("t3_id5",      32'(irq_id),     32'h5);
    chk("t3_status5",  32'(irq_status), 32'h020);
    tick();
    chk("t3_out_hold", 32'(irq_out),    32'h1);
    irq_status_clr  = 10'h020;
    tick();
    irq_status_clr  = '0;
    tick();
    chk("t3_out_fall", 32'(irq_out),    32'h0);
    chk("t3_count",    32'(irq_count),  32'h2);

    // Hold-off of 8: re-raise one cycle after clear
    irq_holdoff     = 8'd8;
    data_event_intr = 10'h001;
    tick();
    tick();
    chk("t4_out_first", 32'(irq_out),   32'h1);
    chk("t4_count3",    32'(irq_count), 32'h3);
    data_event_intr = '0;
    irq_status_clr  = 10'h001;
    tick();
    irq_status_clr  = '0;
    data_event_intr = 10'h001;
    tick();
    chk("t4_status0", 32'(irq_status[0]), 32'h1);
    chk("t4_fall",    32'(irq_out),       32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_low", 32'(irq_out), 32'h0);
    end
    tick();
    chk("t4_reassert", 32'(irq_out),   32'h1);
    chk("t4_count4",   32'(irq_count), 32'h4);
    data_event_intr = '0;
    irq_status_clr  = 10'h001;
    tick();
    irq_status_clr  = '0;
    tick();
    chk("t4_out_off", 32'(irq_out), 32'h0);

    // Overflow on bit 7
    data_event_intr = 10'h080;
    tick();
    chk("t5_status", 32'(irq_status), 32'h080);
    chk("t5_ovf0",   32'(irq_ovf),    32'h000);
    data_event_intr = '0;
    tick();
    data_event_intr = 10'h080;
    tick();
    chk("t5_ovf_set", 32'(irq_ovf), 32'h080);
    data_event_intr = '0;
    tick();
    data_event_intr = 10'h080;
    irq_status_clr  = 10'h080;
    tick();
    data_event_intr = '0;
    irq_status_clr  = '0;
    chk("t5_status_kept", 32'(irq_status), 32'h080);
    chk("t5_ovf_clr",     32'(irq_ovf),    32'h000);

    // Reset while in hold-off with bit 1 held high
    begin
      int guard = 0;
      while (irq_out !== 1'b1 && guard < 30) begin
        tick();
        guard++;
      end
      chk("t6_wait_assert", 32'(irq_out), 32'h1);
    end
    irq_status_clr = 10'h080;
    tick();
    irq_status_clr = '0;
    tick();
    chk("t6_in_holdoff", 32'(irq_out), 32'h0);
    data_event_intr = 10'h002;
    tick();
    chk("t6_pre_status", 32'(irq_status), 32'h002);
    chk("t6_pre_out",    32'(irq_out),    32'h0);
    adc_wclk_rst = 1'b1;
    tick();
    adc_wclk_rst = 1'b0;
    chk("t6_rst_status", 32'(irq_status), 32'h000);
    chk("t6_rst_ovf",    32'(irq_ovf),    32'h000);
    chk("t6_rst_out",    32'(irq_out),    32'h0);
    chk("t6_rst_id",     32'(irq_id),     32'hF);
    chk("t6_rst_count",  32'(irq_count),  32'h0);
    tick();
    chk("t6_retrig_status", 32'(irq_status), 32'h002);
    chk("t6_retrig_id",     32'(irq_id),     32'h1);
    chk("t6_retrig_out0",   32'(irq_out),    32'h0);
    tick();
    chk("t6_retrig_out1",   32'(irq_out),    32'h1);
    chk("t6_count1",        32'(irq_count),  32'h1);

    // Global enable gates the line but not the status
    data_event_intr = '0;
    irq_holdoff     = 8'd0;
    irq_status_clr  = 10'h002;
    tick();
    irq_status_clr  = '0;
    tick();
    chk("t7_out_off", 32'(irq_out), 32'h0);
    irq_en          = 1'b0;
    data_event_intr = 10'h010;
    repeat (3) tick();
    chk("t7_status_dis", 32'(irq_status), 32'h010);
    chk("t7_out_dis",    32'(irq_out),    32'h0);
    irq_en = 1'b1;
    tick();
    chk("t7_out_en",   32'(irq_out),   32'h1);
    chk("t7_count2",   32'(irq_count), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
